// File: rtl/floppy_pkg.sv
// Shared floppy step-driver definitions: coil phases, coil-stage states, track width.
package floppy_pkg;

  localparam logic [3:0] COIL_PH0 = 4'b0001;
  localparam logic [3:0] COIL_PH1 = 4'b0010;
  localparam logic [3:0] COIL_PH2 = 4'b0100;
  localparam logic [3:0] COIL_PH3 = 4'b1000;

  localparam int TRACK_W = 7;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/step_hold_pwm.sv
// Hold-current PWM: free-running period counter with synchronous clear and duty compare.
// gate_nxt is the duty decision for the counter value that follows the next clock edge.
module step_hold_pwm #(
  parameter int PERIOD = 100,
  parameter int DUTY   = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic gate_nxt
);
  logic [7:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + 8'd1;
    if (clr || cnt == 8'(PERIOD - 1)) cnt_nxt = '0;
  end

  assign gate_nxt = {1'b0, cnt_nxt} < 9'(DUTY);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
endmodule

// File: rtl/step_coil_stage.sv
// Coil gating stage: full drive for a settle window after each phase change, then hold; tracks head.
// Define STEP_HOLD_PWM_EN to PWM the hold current; otherwise HOLD drives the coils continuously.
module step_coil_stage
  import floppy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 20000,
  parameter int PWM_PERIOD    = 100,
  parameter int HOLD_DUTY     = 30,
  parameter int MAX_TRACK     = 83
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         coils_in,
  input  logic               track_clr,
  output logic [3:0]         drive,
  output logic [TRACK_W-1:0] track,
  output logic               tr0,
  output logic               holding
);
  localparam int            CW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  if (PWM_PERIOD < 2 || PWM_PERIOD > 255 || HOLD_DUTY < 0 || HOLD_DUTY > PWM_PERIOD ||
      MAX_TRACK > 127 || SETTLE_CYCLES < 1) begin : g_bad_params
    $error("step_coil_stage: parameter out of range");
  end

  state_t             state, ns;
  logic [3:0]         cur, prev, drv_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [TRACK_W-1:0] trk_nxt;
  logic               onehot, chg, fwd, rev, hold_on;

  assign onehot = (cur != 4'b0) && ((cur & (cur - 4'd1)) == 4'b0);
  assign chg    = onehot && (cur != prev);
  assign fwd    = chg && (cur == {prev[2:0], prev[3]});
  assign rev    = chg && (cur == {prev[0], prev[3:1]});

  // Recalibrate wins over any step landing in the same clock.
  always_comb begin
    trk_nxt = track;
    if (track_clr)                                    trk_nxt = '0;
    else if (fwd && track != TRACK_W'(MAX_TRACK))     trk_nxt = track + 1'b1;
    else if (rev && track != '0)                      trk_nxt = track - 1'b1;
  end

  always_comb begin
    ns      = state;
    cnt_nxt = cnt;
    if (!en) begin
      ns      = OFF;
      cnt_nxt = '0;
    end else begin
      case (state)
        OFF: begin
          ns      = DRIVE;
          cnt_nxt = SETTLE_LOAD;
        end
        DRIVE: begin
          if (chg)              cnt_nxt = SETTLE_LOAD;
          else if (cnt == '0)   ns      = HOLD;
          else                  cnt_nxt = cnt - 1'b1;
        end
        HOLD: begin
          if (chg) begin
            ns      = DRIVE;
            cnt_nxt = SETTLE_LOAD;
          end
        end
        default: ns = OFF;
      endcase
    end
  end

`ifdef STEP_HOLD_PWM_EN
  // Counter sits at 0 outside HOLD so each hold window starts at the top of a period.
  step_hold_pwm #(
    .PERIOD (PWM_PERIOD),
    .DUTY   (HOLD_DUTY)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != HOLD),
    .gate_nxt (hold_on)
  );
`else
  assign hold_on = 1'b1;
`endif

  always_comb begin
    drv_nxt = cur;
    if (ns == OFF || !onehot || (ns == HOLD && !hold_on)) drv_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cur   <= COIL_PH0;
      prev  <= COIL_PH0;
      cnt   <= '0;
      drive <= '0;
      track <= '0;
      tr0   <= 1'b1;
    end else begin
      state <= ns;
      cur   <= coils_in;
      if (chg) prev <= cur;
      cnt   <= cnt_nxt;
      drive <= drv_nxt;
      track <= trk_nxt;
      tr0   <= (trk_nxt == '0);
    end
  end

  assign holding = (state == HOLD);

endmodule

// File: tb/tb_step_coil_stage.sv
// Randomized + directed bench for step_coil_stage against a phase-index / settle-age reference model.
module tb_step_coil_stage;
  localparam int S    = 64;
  localparam int P    = 10;
  localparam int D    = 3;
  localparam int MAXT = 83;

  logic       clk = 1'b0;
  logic       rst, en, track_clr;
  logic [3:0] coils_in, drive;
  logic [6:0] track;
  logic       tr0, holding;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [3:0] m_cur, m_prev, m_drv;
  int         m_trk, m_age;
  bit         m_act;

  step_coil_stage #(
    .SETTLE_CYCLES (S),
    .PWM_PERIOD    (P),
    .HOLD_DUTY     (D),
    .MAX_TRACK     (MAXT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .coils_in  (coils_in),
    .track_clr (track_clr),
    .drive     (drive),
    .track     (track),
    .tr0       (tr0),
    .holding   (holding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int idx(input logic [3:0] v);
    return v[0] ? 0 : v[1] ? 1 : v[2] ? 2 : 3;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] rotr(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare at the falling edge.
  task automatic cyc();
    bit oh, ch, hold, on;
    int d;
    @(posedge clk);
    if (rst) begin
      m_cur = 4'b0001; m_prev = 4'b0001; m_trk = 0; m_act = 0; m_age = 0; m_drv = '0;
    end else begin
      oh = ($countones(m_cur) == 1);
      ch = oh && (m_cur != m_prev);
      if (track_clr) m_trk = 0;
      else if (ch) begin
        d = (idx(m_cur) - idx(m_prev)) & 3;
        if (d == 1 && m_trk < MAXT) m_trk++;
        else if (d == 3 && m_trk > 0) m_trk--;
      end
      if (ch) m_prev = m_cur;
      if (!en) begin m_act = 0; m_age = 0; end
      else if (!m_act || ch) begin m_act = 1; m_age = 0; end
      else m_age++;
      hold = m_act && (m_age >= S);
`ifdef STEP_HOLD_PWM_EN
      on = !hold || (((m_age - S) % P) < D);
`else
      on = 1'b1;
`endif
      m_drv = (m_act && oh && on) ? m_cur : 4'b0;
      m_cur = coils_in;
    end
    @(negedge clk);
    chk("drive",   32'(drive),   32'(m_drv));
    chk("track",   32'(track),   32'(m_trk));
    chk("tr0",     32'(tr0),     32'(m_trk == 0));
    chk("holding", 32'(holding), 32'(m_act && m_age >= S));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic step_to(input logic [3:0] c, input int n);
    coils_in = c;
    run(n);
  endtask

  initial begin
    logic [3:0] c;
    int r, len;
    rst = 1'b1; en = 1'b0; track_clr = 1'b0; coils_in = 4'b0001;
    run(3);
    chk("reset_track", 32'(track), 32'd0);
    chk("reset_tr0",   32'(tr0),   32'd1);
    rst = 1'b0;
    run(2);

    // power up on phase 0, settle into hold and watch a few PWM periods
    en = 1'b1;
    run(S + 3 * P + 5);
    chk("hold_reached", 32'(holding), 32'd1);

    // four forward steps, each restarting settle
    step_to(4'b0010, 10);
    step_to(4'b0100, 10);
    step_to(4'b1000, 10);
    step_to(4'b0001, 10);
    chk("fwd4_track", 32'(track), 32'd4);
    chk("fwd4_tr0",   32'(tr0),   32'd0);

    // reverse well past track 0
    c = 4'b0001;
    for (int i = 0; i < 7; i++) begin c = rotr(c); step_to(c, 3); end
    chk("rev_floor", 32'(track), 32'd0);

    // forward well past MAX_TRACK
    for (int i = 0; i < MAXT + 6; i++) begin c = rotl(c); step_to(c, 2); end
    chk("fwd_ceiling", 32'(track), 32'(MAXT));

    // non-one-hot input, then a two-phase jump
    step_to(4'b0011, 5);
    step_to(4'b0001, 4);
    step_to(4'b0100, S + 2 * P);
    chk("jump_track", 32'(track), 32'(MAXT));

    // recalibrate, walk out to track 5, then clear coincident with a forward step
    track_clr = 1'b1; run(1); track_clr = 1'b0;
    c = 4'b0100;
    for (int i = 0; i < 5; i++) begin c = rotl(c); step_to(c, 2); end
    chk("at_track5", 32'(track), 32'd5);
    coils_in = rotl(c); run(1);
    track_clr = 1'b1; run(1); track_clr = 1'b0;
    run(3);
    chk("clr_priority", 32'(track), 32'd0);

    // drop enable while holding
    run(S + 5);
    en = 1'b0; run(1);
    chk("en_drop_drive", 32'(drive), 32'd0);
    run(3);
    en = 1'b1;

    // randomized traffic
    c = coils_in;
    for (int it = 0; it < 350; it++) begin
      r = $urandom_range(0, 9);
      if (r >= 5 && r <= 6)  c = rotl(($countones(c) == 1) ? c : 4'b0001);
      else if (r == 7)       c = rotr(($countones(c) == 1) ? c : 4'b0001);
      else if (r == 8)       c = 4'b0001 << $urandom_range(0, 3);
      else if (r == 9)       c = 4'($urandom_range(0, 15));
      coils_in  = c;
      en        = ($urandom_range(0, 19) != 0);
      track_clr = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(S, S + 3 * P) : $urandom_range(1, 4);
      run(1);
      track_clr = 1'b0; rst = 1'b0;
      run(len - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/step_coil_stage.md
# step_coil_stage

Downstream stage of the floppy step driver. Consumes its one-hot 4-bit coil pattern and produces the gated coil drive lines. Coils get full drive for a settle window after every phase change, then drop to a reduced PWM hold current. The block also tracks head position from phase transitions and generates the TRK00 (`tr0`) indication fed back to the host interface and the step driver.

## Interface

Parameters:
- `SETTLE_CYCLES`, 20000: full-drive clocks after any phase change or enable.
- `PWM_PERIOD`, 100: hold PWM period in clocks, 2..255.
- `HOLD_DUTY`, 30: hold on-clocks per period, 0..`PWM_PERIOD`.
- `MAX_TRACK`, 83: highest reachable track, ≤127.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `en`, input, 1: drive enable (drive select and motor).
- `coils_in`, input, 4: one-hot coil phase from the step driver.
- `track_clr`, input, 1: one-cycle pulse that forces the track count to 0 (recalibrate).
- `drive`, output, 4: gated coil outputs to the power stage.
- `track`, output, 7: current head track.
- `tr0`, output, 1: high when `track == 0`.
- `holding`, output, 1: high while in `HOLD`.

## Operation

- `coils_in` is registered once into `cur`. `prev` holds the last valid one-hot value. `prev` resets to `4'b0001`, matching the upstream reset phase.
- Phase change: `cur` is one-hot and `cur != prev`.
  - `cur == rotl(prev,1)` is a forward step: track +1, saturating at `MAX_TRACK`.
  - `cur == rotr(prev,1)` is a reverse step: track −1, saturating at 0.
  - Any other one-hot change (a two-phase jump) is treated as a phase change with no track update.
  - Non-one-hot `cur`: `drive` = 0, `prev` and `track` are unchanged, and no phase change is recognised.
- `track_clr` forces track to 0 and takes priority over a simultaneous step.
- States:
  - `OFF`: `drive` = 0, `holding` = 0. Go to `DRIVE` when `en` is 1, loading the settle counter with `SETTLE_CYCLES−1`.
  - `DRIVE`: `drive` = `cur`. The counter decrements each clock. At counter = 0, go to `HOLD` and clear the PWM counter. A phase change reloads the counter.
  - `HOLD`: `drive` = `cur` when `pwm_cnt < HOLD_DUTY`, otherwise 0. `pwm_cnt` wraps at `PWM_PERIOD−1`. A phase change returns to `DRIVE` with the counter reloaded.
  - From any state, `en` = 0 goes to `OFF` on the next clock.
- Track counting runs whenever the phase changes, regardless of `en`. The upstream driver only steps when enabled.
- Reset values: state `OFF`, `drive` = 0, `track` = 0, `tr0` = 1, `holding` = 0, `pwm_cnt` = 0, settle counter = 0.

## Timing

- `drive`, `track`, `tr0` and `holding` are all registered.
- A `coils_in` change reaches `cur` one clock later. `drive` and `track` reflect it on the following clock, so input-to-output latency is 2 clocks.
- `tr0` updates in the same cycle as `track`.
- After a phase change, `holding` rises exactly `SETTLE_CYCLES` clocks after `drive` first shows the new phase.
- `en` falling gives `drive` = 0 within 1 clock.
- Reset asserted mid-settle or mid-hold: the next clock reaches reset values. `track` is lost and a recalibrate is required.
- `HOLD_DUTY = 0` means hold drive is always 0. `HOLD_DUTY = PWM_PERIOD` means always on.

## Configuration

- `STEP_HOLD_PWM_EN` defined: `HOLD` applies the PWM gating described in Operation.
- `STEP_HOLD_PWM_EN` undefined:
  - `HOLD` drives `drive` = `cur` continuously.
  - The PWM counter and its comparator are not built.
  - `holding` and the settle timing are unchanged.

## Structure

- Shared package `floppy_pkg` holds:
  - the coil phase constants `COIL_PH0..COIL_PH3` (`4'b0001..4'b1000`);
  - the state enum (`OFF`, `DRIVE`, `HOLD`);
  - the track width constant (7).
- One sub-module, `step_hold_pwm`: a free-running counter plus duty comparator with a synchronous clear. It is instantiated only under `STEP_HOLD_PWM_EN`.

## Test plan

- Reset, then `en` = 1 with `coils_in` = `0001` → `drive` = `0001` full, `track` = 0, `tr0` = 1, `holding` = 1 after 20000 clocks.
- Apply the sequence `0010`, `0100`, `1000`, `0001` → `track` = 4 and `tr0` = 0. Each change restarts settle, so `holding` drops to 0 for 20000 clocks.
- Reverse steps from track 1 down past 0 → `track` stays 0 and `tr0` = 1. Forward past 83 → `track` stays 83.
- In `HOLD` with defaults → `drive` is high 30 of every 100 clocks. Without the macro, `drive` is continuously high.
- Drive `coils_in` = `0011` and then a jump `0001`→`0100` → `drive` = 0 for `0011`, `track` is unchanged on both, and the jump restarts settle.
- Assert `track_clr` together with a forward step at track 5 → `track` = 0. Drop `en` in `HOLD` → `drive` = 0 the next clock.
